// File: rtl/i2c_cfg_arbiter.sv
// Round-robin share of one I2C register-write master between DAC and ADC requesters; grant->m_start 2 clk, done/err 1 clk after m_done.
// Level requests simply wait while busy; optional I2C_CFG_RETRY_ON_NACK_EN reissues NACKed writes up to twice.
module i2c_cfg_arbiter #(
   parameter int ADDR_W     = 7,
   parameter int REG_W      = 8,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 16,
   parameter int TIMEOUT    = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_dac,
   input  logic [ADDR_W-1:0] i2c_addr_dac,
   input  logic [REG_W-1:0]  reg_addr_dac,
   input  logic [DATA_W-1:0] i2c_data_dac,
   output logic              done_dac,
   output logic              err_dac,
   input  logic              req_adc,
   input  logic [ADDR_W-1:0] i2c_addr_adc,
   input  logic [REG_W-1:0]  reg_addr_adc,
   input  logic [DATA_W-1:0] i2c_data_adc,
   output logic              done_adc,
   output logic              err_adc,
   output logic              m_start,
   output logic [ADDR_W-1:0] m_dev_addr,
   output logic [REG_W-1:0]  m_reg_addr,
   output logic [DATA_W-1:0] m_data,
   output logic              m_abort,
   input  logic              m_done,
   input  logic              m_nack,
   output logic              owner,
   output logic              busy
);
   localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             last_owner, last_owner_nxt;
   logic             grant, grant_sel;
   logic             start_nxt, abort_nxt, done_nxt, err_nxt;
`ifdef I2C_CFG_RETRY_ON_NACK_EN
   logic [1:0]       retry_cnt, retry_cnt_nxt;
   logic             retry_pend, retry_pend_nxt;
`endif

   // On a tie the requester that was not served last wins.
   assign grant_sel = (req_dac && req_adc) ? ~last_owner : req_adc;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_owner_nxt = last_owner;
      grant          = 1'b0;
      start_nxt      = 1'b0;
      abort_nxt      = 1'b0;
      done_nxt       = 1'b0;
      err_nxt        = 1'b0;
`ifdef I2C_CFG_RETRY_ON_NACK_EN
      retry_cnt_nxt  = retry_cnt;
      retry_pend_nxt = retry_pend;
`endif
      case (state)
         IDLE: begin
            if (req_dac || req_adc) begin
               grant     = 1'b1;
               state_nxt = ISSUE;
`ifdef I2C_CFG_RETRY_ON_NACK_EN
               retry_cnt_nxt = 2'd0;
`endif
            end
         end
         ISSUE: begin
            start_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A completion in the expiry cycle takes priority over the timeout.
            if (m_done) begin
               cnt_nxt   = '0;
               state_nxt = GAP;
`ifdef I2C_CFG_RETRY_ON_NACK_EN
               if (m_nack && (retry_cnt < 2'd2)) begin
                  retry_cnt_nxt  = retry_cnt + 2'd1;
                  retry_pend_nxt = 1'b1;
               end else begin
                  done_nxt       = 1'b1;
                  err_nxt        = m_nack;
                  last_owner_nxt = owner;
               end
`else
               done_nxt       = 1'b1;
               err_nxt        = m_nack;
               last_owner_nxt = owner;
`endif
            end else if (cnt == WAIT_LAST) begin
               abort_nxt      = 1'b1;
               done_nxt       = 1'b1;
               err_nxt        = 1'b1;
               last_owner_nxt = owner;
               cnt_nxt        = '0;
               state_nxt      = GAP;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         GAP: begin
            // The report cycle plus GAP_CYCLES idle cycles before the bus is offered again.
            if (cnt == GAP_LAST) begin
               cnt_nxt   = '0;
`ifdef I2C_CFG_RETRY_ON_NACK_EN
               state_nxt      = retry_pend ? ISSUE : IDLE;
               retry_pend_nxt = 1'b0;
`else
               state_nxt = IDLE;
`endif
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_owner <= 1'b1;
         owner      <= 1'b0;
         m_start    <= 1'b0;
         m_abort    <= 1'b0;
         m_dev_addr <= '0;
         m_reg_addr <= '0;
         m_data     <= '0;
         done_dac   <= 1'b0;
         err_dac    <= 1'b0;
         done_adc   <= 1'b0;
         err_adc    <= 1'b0;
`ifdef I2C_CFG_RETRY_ON_NACK_EN
         retry_cnt  <= 2'd0;
         retry_pend <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_owner <= last_owner_nxt;
         m_start    <= start_nxt;
         m_abort    <= abort_nxt;
         done_dac   <= done_nxt & ~owner;
         err_dac    <= err_nxt & ~owner;
         done_adc   <= done_nxt & owner;
         err_adc    <= err_nxt & owner;
`ifdef I2C_CFG_RETRY_ON_NACK_EN
         retry_cnt  <= retry_cnt_nxt;
         retry_pend <= retry_pend_nxt;
`endif
         if (grant) begin
            owner      <= grant_sel;
            m_dev_addr <= grant_sel ? i2c_addr_adc : i2c_addr_dac;
            m_reg_addr <= grant_sel ? reg_addr_adc : reg_addr_dac;
            m_data     <= grant_sel ? i2c_data_adc : i2c_data_dac;
         end
      end
   end
endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Bench for i2c_cfg_arbiter: directed cases plus randomized transactions against a transaction-level model.
module tb_i2c_cfg_arbiter;
   localparam int AW  = 7;
   localparam int RW  = 8;
   localparam int DW  = 8;
   localparam int GAP = 4;
   localparam int TMO = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_dac = 1'b0, req_adc = 1'b0;
   logic [AW-1:0] i2c_addr_dac, i2c_addr_adc;
   logic [RW-1:0] reg_addr_dac, reg_addr_adc;
   logic [DW-1:0] i2c_data_dac, i2c_data_adc;
   logic          done_dac, err_dac, done_adc, err_adc;
   logic          m_start, m_abort, owner, busy;
   logic [AW-1:0] m_dev_addr;
   logic [RW-1:0] m_reg_addr;
   logic [DW-1:0] m_data;
   logic          m_done = 1'b0, m_nack = 1'b0;

   logic [AW-1:0] f_dev [2];
   logic [RW-1:0] f_reg [2];
   logic [DW-1:0] f_dat [2];
   bit            model_last;
   int            tests = 0;
   int            fails = 0;

   assign i2c_addr_dac = f_dev[0];
   assign reg_addr_dac = f_reg[0];
   assign i2c_data_dac = f_dat[0];
   assign i2c_addr_adc = f_dev[1];
   assign reg_addr_adc = f_reg[1];
   assign i2c_data_adc = f_dat[1];

   always #5 clk = ~clk;

   i2c_cfg_arbiter #(.ADDR_W(AW), .REG_W(RW), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_dac(req_dac), .i2c_addr_dac(i2c_addr_dac), .reg_addr_dac(reg_addr_dac),
      .i2c_data_dac(i2c_data_dac), .done_dac(done_dac), .err_dac(err_dac),
      .req_adc(req_adc), .i2c_addr_adc(i2c_addr_adc), .reg_addr_adc(reg_addr_adc),
      .i2c_data_adc(i2c_data_adc), .done_adc(done_adc), .err_adc(err_adc),
      .m_start(m_start), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_data(m_data),
      .m_abort(m_abort), .m_done(m_done), .m_nack(m_nack), .owner(owner), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_fields(input bit who, input logic [AW-1:0] d, input logic [RW-1:0] r,
                             input logic [DW-1:0] v);
      f_dev[who] = d;
      f_reg[who] = r;
      f_dat[who] = v;
   endtask

   task automatic rand_fields(input bit who);
      set_fields(who, AW'($urandom), RW'($urandom), DW'($urandom));
   endtask

   // Expected arbitration outcome from the round-robin rule.
   function automatic bit pick(input bit d, input bit a);
      return (d && a) ? ~model_last : a;
   endfunction

   // Serve one transaction starting from an idle cycle: start latency, latched fields,
   // completion/timeout timing, then the post-transaction quiet interval.
   task automatic serve(input bit own, input int delay, input bit nack, input bit tmo, input bit spur);
      int k, j, xs, sd;
      bit got;
      k = 0;
      do begin @(negedge clk); k++; end while (!m_start && k < 8);
      chk("start_latency", 32'(k), 32'd2);
      chk("owner", 32'(owner), 32'(own));
      chk("busy_active", 32'(busy), 32'd1);
      chk("m_dev_addr", 32'(m_dev_addr), 32'(f_dev[own]));
      chk("m_reg_addr", 32'(m_reg_addr), 32'(f_reg[own]));
      chk("m_data", 32'(m_data), 32'(f_dat[own]));
      j = 0; got = 0; xs = 0;
      while (!got && j < TMO + 8) begin
         if (!tmo && j == delay) begin m_done = 1'b1; m_nack = nack; end
         @(negedge clk); j++;
         m_done = 1'b0; m_nack = 1'b0;
         if (m_start) xs++;
         got = done_dac | done_adc;
      end
      chk("done_cycle", 32'(j), tmo ? 32'(TMO) : 32'(delay + 1));
      chk("done_owner", 32'(own ? done_adc : done_dac), 32'd1);
      chk("done_other", 32'(own ? done_dac : done_adc), 32'd0);
      chk("err", 32'(own ? err_adc : err_dac), 32'(tmo | nack));
      chk("m_abort", 32'(m_abort), 32'(tmo));
      if (own) req_adc = 1'b0; else req_dac = 1'b0;
      model_last = own;
      k = 0; sd = 0;
      do begin
         if (spur && k == 1) begin m_done = 1'b1; m_nack = 1'b1; end
         @(negedge clk); k++;
         m_done = 1'b0; m_nack = 1'b0;
         if (done_dac | done_adc | m_abort) sd++;
         if (m_start) xs++;
      end while (busy && k < GAP + 8);
      chk("gap_length", 32'(k), 32'(GAP + 1));
      chk("no_done_in_gap", 32'(sd), 32'd0);
      chk("single_start", 32'(xs), 32'd0);
   endtask

`ifdef I2C_CFG_RETRY_ON_NACK_EN
   // NACK n_nack times (answering each start at once), then ACK.
   task automatic retry_seq(input int n_nack);
      int starts, cyc;
      bit got, e;
      starts = 0; cyc = 0; got = 0; e = 1'b0;
      while (!got && cyc < 400) begin
         @(negedge clk); cyc++;
         m_done = 1'b0; m_nack = 1'b0;
         got = done_dac;
         if (got) e = err_dac;
         if (m_start) begin
            starts++;
            m_done = 1'b1;
            m_nack = (starts <= n_nack);
         end
      end
      chk("retry_starts", 32'(starts), (n_nack >= 3) ? 32'd3 : 32'(n_nack + 1));
      chk("retry_err", 32'(e), (n_nack >= 3) ? 32'd1 : 32'd0);
      req_dac = 1'b0;
      model_last = 1'b0;
      cyc = 0;
      while (busy && cyc < GAP + 8) begin @(negedge clk); cyc++; end
      chk("retry_idle", 32'(busy), 32'd0);
   endtask
`endif

   initial begin
      int sd, p, dly;
      bit d, a, w, tm, nk;
      set_fields(1'b0, '0, '0, '0);
      set_fields(1'b1, '0, '0, '0);
      model_last = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outputs", 32'({m_start, m_abort, done_dac, err_dac, done_adc, err_adc, owner}), 32'd0);
      chk("rst_fields", 32'({m_dev_addr, m_reg_addr, m_data}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Lone DAC write, ACK 20 cycles after start.
      set_fields(1'b0, 7'h1A, 8'h10, 8'h55);
      req_dac = 1'b1;
      serve(1'b0, 20, 1'b0, 1'b0, 1'b0);

      // Reset while waiting on the master: immediate idle, no pulses, later m_done ignored.
      set_fields(1'b0, 7'h33, 8'h44, 8'h99);
      req_dac = 1'b1;
      sd = 0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_wait_busy", 32'(busy), 32'd0);
      chk("rst_wait_pulses", 32'({m_start, m_abort, done_dac, done_adc, err_dac}), 32'd0);
      req_dac = 1'b0;
      rst = 1'b0;
      model_last = 1'b1;
      m_done = 1'b1;
      repeat (4) begin
         @(negedge clk);
         m_done = 1'b0;
         if (done_dac | done_adc | busy | m_abort | m_start) sd++;
      end
      chk("idle_spurious_done", 32'(sd), 32'd0);

      // Ties: DAC first out of reset, then ADC, then DAC again.
      set_fields(1'b0, 7'h1A, 8'h10, 8'h55);
      set_fields(1'b1, 7'h2B, 8'h10, 8'h77);
      req_dac = 1'b1; req_adc = 1'b1;
      serve(pick(1'b1, 1'b1), 10, 1'b0, 1'b0, 1'b0);
      serve(1'b1, 7, 1'b0, 1'b0, 1'b0);
      req_dac = 1'b1; req_adc = 1'b1;
      chk("tie_alternates", 32'(pick(1'b1, 1'b1)), 32'd0);
      serve(1'b0, 3, 1'b0, 1'b0, 1'b0);
      serve(1'b1, 0, 1'b0, 1'b0, 1'b0);

      // ADC timeout, then completion exactly in the expiry cycle, with a spurious m_done in GAP.
      req_adc = 1'b1;
      serve(1'b1, 0, 1'b0, 1'b1, 1'b0);
      req_adc = 1'b1;
      serve(1'b1, TMO - 1, 1'b0, 1'b0, 1'b1);

      // NACK on a DAC write.
      set_fields(1'b0, 7'h1A, 8'h10, 8'h55);
      req_dac = 1'b1;
`ifdef I2C_CFG_RETRY_ON_NACK_EN
      retry_seq(3);
      req_dac = 1'b1;
      retry_seq(1);
`else
      serve(1'b0, 5, 1'b1, 1'b0, 1'b0);
`endif

      // Randomized traffic.
      for (int it = 0; it < 25; it++) begin
         p = $urandom_range(1, 3);
         d = p[0]; a = p[1];
         if (d) rand_fields(1'b0);
         if (a) rand_fields(1'b1);
         w = pick(d, a);
         req_dac = d; req_adc = a;
         for (int n = 0; n < (d && a ? 2 : 1); n++) begin
            tm  = ($urandom_range(0, 9) == 0);
            dly = $urandom_range(0, TMO - 1);
`ifdef I2C_CFG_RETRY_ON_NACK_EN
            nk  = 1'b0;
`else
            nk  = $urandom_range(0, 1) != 0;
`endif
            serve(n == 0 ? w : ~w, dly, nk, tm, $urandom_range(0, 3) == 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
